// File: rtl/ai_scorer_pkg.sv
// Shared definitions for the frame scorer and the comparer's distance stages.
//   state_t   : frame scorer control states
//   acc_width : score width that cannot overflow for a given sample width and
//               frame length (one bit for the signed difference, log2(N) for
//               the sum of N magnitudes)
package ai_scorer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic int acc_width(input int data_width, input int frame_len);
    return data_width + 1 + $clog2(frame_len);
  endfunction

endpackage

// File: rtl/ai_abs_diff.sv
// Combinational magnitude of the signed difference |i_a - i_b|.
// Ports:
//   i_a, i_b : DATA_WIDTH two's-complement operands
//   o_abs    : DATA_WIDTH+1 unsigned magnitude (covers full-scale opposite signs)
module ai_abs_diff #(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  output logic        [DATA_WIDTH:0]   o_abs
);

  logic signed [DATA_WIDTH:0] w_diff;
  logic signed [DATA_WIDTH:0] w_neg;

  // Operands are sign-extended by one bit so the subtraction cannot wrap.
  assign w_diff = (DATA_WIDTH+1)'(i_a) - (DATA_WIDTH+1)'(i_b);
  assign w_neg  = -w_diff;
  assign o_abs  = w_diff[DATA_WIDTH] ? $unsigned(w_neg) : $unsigned(w_diff);

endmodule

// File: rtl/ai_frame_scorer.sv
// Frame scorer: pops FRAME_LEN signed samples from the comparer's sample FIFO,
// reads the matching template words, and reports the L1 distance of the frame.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin one frame (sampled only while idle)
//   busy        : high whenever a frame is in progress
//   fifo_empty  : FIFO empty flag
//   fifo_r_en   : FIFO read enable (a read is accepted whenever this is high)
//   fifo_data   : FIFO registered read data, valid the cycle after a read
//   tmpl_addr   : template memory address (synchronous, 1-cycle latency)
//   tmpl_data   : template word
//   score       : L1 distance of the last completed frame, held until the next
//   score_valid : one-cycle pulse when score updates
module ai_frame_scorer
  import ai_scorer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 64,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, FRAME_LEN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  input  logic                           fifo_empty,
  output logic                           fifo_r_en,
  input  logic signed [DATA_WIDTH-1:0]   fifo_data,
  output logic [$clog2(FRAME_LEN)-1:0]   tmpl_addr,
  input  logic signed [DATA_WIDTH-1:0]   tmpl_data,
  output logic [ACC_WIDTH-1:0]           score,
  output logic                           score_valid
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic                  r_rd_vld;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_score;
  logic                  r_score_valid;
  logic                  w_accept;
  logic [DATA_WIDTH:0]   w_abs;

  ai_abs_diff #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_abs_diff (
    .i_a  (fifo_data),
    .i_b  (tmpl_data),
    .o_abs(w_abs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = RUN;
        end
      end
      RUN: begin
        // Leaving RUN on the last accepted read keeps r_en from ever
        // asserting for a sample beyond the frame.
        w_accept = !fifo_empty;
        if (w_accept && (r_cnt == LAST_IDX)) begin
          w_next = DRAIN;
        end
      end
      DRAIN:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: the address tracks the issue count, so FIFO data and template
  // word arrive together in the cycle flagged by r_rd_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_rd_vld      <= 1'b0;
      r_acc         <= '0;
      r_score       <= '0;
      r_score_valid <= 1'b0;
    end else begin
      r_score_valid <= 1'b0;
      r_rd_vld      <= w_accept;
      if (r_rd_vld) begin
        r_acc <= r_acc + ACC_WIDTH'(w_abs);
      end
      if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == IDLE) && start) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
      if (r_state == DONE) begin
        r_score       <= r_acc;
        r_score_valid <= 1'b1;
      end
    end
  end

  assign fifo_r_en   = w_accept;
  assign busy        = (r_state != IDLE);
  assign tmpl_addr   = r_cnt[AW-1:0];
  assign score       = r_score;
  assign score_valid = r_score_valid;

endmodule

// File: tb/tb_ai_frame_scorer.sv
module tb_ai_frame_scorer;

  localparam int DW   = 16;
  localparam int FL   = 4;
  localparam int AW   = 2;
  localparam int ACCW = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst   = 1'b1;
  logic                   start = 1'b0;
  logic                   stall = 1'b0;
  logic                   busy;
  logic                   fifo_empty;
  logic                   fifo_r_en;
  logic signed [DW-1:0]   fifo_dout;
  logic [AW-1:0]          tmpl_addr;
  logic signed [DW-1:0]   tmpl_data;
  logic [ACCW-1:0]        score;
  logic                   score_valid;

  ai_frame_scorer #(
    .DATA_WIDTH(DW),
    .FRAME_LEN (FL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_data  (fifo_dout),
    .tmpl_addr  (tmpl_addr),
    .tmpl_data  (tmpl_data),
    .score      (score),
    .score_valid(score_valid)
  );

  // FIFO with registered read data; its contents survive the scorer's reset.
  logic signed [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = stall || (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_r_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Template memory, synchronous read.
  logic signed [DW-1:0] tmpl [0:FL-1];
  always @(posedge clk) tmpl_data <= tmpl[tmpl_addr];

  // Frame-level model: a frame starts on start while idle, takes the next FL
  // FIFO samples as they become available, and two edges after the last pop
  // publishes sum |sample_i - tmpl[i]| with a one-cycle valid, going idle.
  int     cyc    = 0;
  bit     m_busy = 1'b0;
  int     m_npop = 0;
  longint m_sum  = 0;
  longint m_score = 0;
  bit     m_valid = 1'b0;
  int     m_due  = -1;

  function automatic longint absl(input longint x);
    return (x < 0) ? -x : x;
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    m_valid <= 1'b0;
    if (rst) begin
      m_busy  <= 1'b0;
      m_npop  <= 0;
      m_sum   <= 0;
      m_score <= 0;
      m_due   <= -1;
    end else begin
      if (!m_busy && start) begin
        m_busy <= 1'b1;
        m_npop <= 0;
        m_sum  <= 0;
      end
      if (m_busy && (m_npop < FL) && !fifo_empty) begin
        m_npop <= m_npop + 1;
        m_sum  <= m_sum + absl(longint'(mem[rd_ptr]) - longint'(tmpl[m_npop]));
        if (m_npop == FL - 1) m_due <= cyc + 2;
      end
      if (cyc == m_due) begin
        m_busy  <= 1'b0;
        m_score <= m_sum;
        m_valid <= 1'b1;
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    @(negedge clk);
    chk("score",       longint'(score), m_score);
    chk("score_valid", longint'(score_valid), longint'(m_valid));
    chk("busy",        longint'(busy), longint'(m_busy));
    chk("fifo_r_en",   longint'(fifo_r_en),
        longint'(m_busy && (m_npop < FL) && !fifo_empty));
    chk("tmpl_addr",   longint'(tmpl_addr), longint'(m_npop % FL));
  endtask

  task automatic push(input logic signed [DW-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic set_tmpl(input int a, input int b, input int c, input int d);
    tmpl[0] = DW'(a);
    tmpl[1] = DW'(b);
    tmpl[2] = DW'(c);
    tmpl[3] = DW'(d);
  endtask

  // Pulses start at the current falling edge and runs until score_valid,
  // checking the hand-computed score, latency (ticks; tick 1 follows the
  // start edge) and read count. Optional stall and start re-pulse.
  task automatic run_frame(input longint exp_score, input int exp_k,
                           input int stall_at, input int stall_len,
                           input bit repulse, input longint prev_score);
    int k;
    bit seen;
    int rd0;
    rd0   = rd_ptr;
    start = 1'b1;
    k     = 0;
    seen  = 1'b0;
    while (!seen && k < 60) begin
      tick();
      k++;
      if (k == 1) start = 1'b0;
      if (repulse && k == 2) start = 1'b1;
      if (repulse && k == 3) start = 1'b0;
      if (k == 3) chk("score_hold", longint'(score), prev_score);
      if (stall_len > 0 && k == stall_at) stall = 1'b1;
      if (stall_len > 0 && k == stall_at + 1) begin
        chk("stall_r_en", longint'(fifo_r_en), 0);
        chk("stall_addr", longint'(tmpl_addr), longint'(stall_at - 1));
      end
      if (stall_len > 0 && k == stall_at + stall_len) stall = 1'b0;
      if (score_valid) seen = 1'b1;
    end
    chk("frame_done",  longint'(seen), 1);
    chk("score_lit",   longint'(score), exp_score);
    chk("latency",     longint'(k), longint'(exp_k));
    chk("reads",       longint'(rd_ptr - rd0), FL);
    chk("busy_at_vld", longint'(busy), 0);
  endtask

  initial begin
    set_tmpl(12, 18, 30, 45);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_score", longint'(score), 0);
    chk("rst_busy",  longint'(busy), 0);

    // Basic frame: |10-12|+|20-18|+|30-30|+|40-45| = 9
    push(10); push(20); push(30); push(40);
    run_frame(9, 7, 0, 0, 1'b0, 0);
    tick();
    chk("busy_after", longint'(busy), 0);

    // Signed handling: 4 * 200
    set_tmpl(100, 100, 100, 100);
    for (int i = 0; i < 4; i++) push(-16'sd100);
    run_frame(800, 7, 0, 0, 1'b0, 9);
    tick();

    // Full-scale opposite signs: 4 * 65535
    set_tmpl(32767, 32767, 32767, 32767);
    for (int i = 0; i < 4; i++) push(-16'sd32768);
    run_frame(262140, 7, 0, 0, 1'b0, 800);
    tick();

    // Three empty cycles after the second sample
    set_tmpl(12, 18, 30, 45);
    push(10); push(20); push(30); push(40);
    run_frame(9, 10, 3, 3, 1'b0, 262140);
    tick();

    // start re-pulsed mid-frame, then back-to-back frames: 95, then 91
    push(1); push(2); push(3); push(4);
    push(50); push(0); push(-16'sd5); push(45);
    run_frame(95, 7, 0, 0, 1'b1, 9);
    run_frame(91, 7, 0, 0, 1'b0, 95);
    tick();

    // Reset after two accepted reads abandons the frame
    push(7); push(7);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_busy",  longint'(busy), 0);
    chk("abort_r_en",  longint'(fifo_r_en), 0);
    chk("abort_addr",  longint'(tmpl_addr), 0);
    chk("abort_score", longint'(score), 0);
    chk("abort_vld",   longint'(score_valid), 0);
    rst = 1'b0;
    tick();
    push(10); push(20); push(30); push(40);
    run_frame(9, 7, 0, 0, 1'b0, 0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
